// File: rtl/usr_serial_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : usr_serial_deserializer_if
// Description : Serial-in / parallel-out bundle for the USR link receiver.
// Revision    : 1.0  initial release
// ============================================================================
interface usr_serial_deserializer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             serial_in;
    logic             serial_valid;
    logic             lsb_first;
    logic             abort;
    logic             out_ready;
    logic             clear_ovr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_count;
    logic             overrun;

    modport master (
        output serial_in, serial_valid, lsb_first, abort, out_ready, clear_ovr,
        input  data_out, data_valid, busy, bit_count, overrun
    );

    modport slave (
        input  serial_in, serial_valid, lsb_first, abort, out_ready, clear_ovr,
        output data_out, data_valid, busy, bit_count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/usr_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : usr_serial_deserializer
// Description : Rebuilds parallel words from a USR serial stream (MSB- or
//               LSB-first) into a one-entry valid/ready output register.
// Revision    : 1.0  initial release
// ============================================================================
module usr_serial_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic               clock,
    input  wire logic               reset,
    usr_serial_deserializer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_order;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovr;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_order_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_valid_nxt;
    logic             w_ovr_nxt;
    logic             w_order_use;
    logic [WIDTH-1:0] w_shifted;

    // The first bit of a frame uses the live order input; later bits use the latched one.
    assign w_order_use = (r_state == ST_IDLE) ? bus.lsb_first : r_order;
    assign w_shifted   = w_order_use ? {bus.serial_in, r_sh[WIDTH-1:1]}
                                     : {r_sh[WIDTH-2:0], bus.serial_in};

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_order_nxt = r_order;
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_valid & ~bus.out_ready;
        w_ovr_nxt   = r_ovr & ~bus.clear_ovr;

        case (r_state)
            ST_IDLE: begin
                if (!bus.abort && bus.serial_valid) begin
                    w_order_nxt = bus.lsb_first;
                    w_sh_nxt    = w_shifted;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.abort) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.serial_valid) begin
                    w_sh_nxt = w_shifted;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                        // A word still held and not being taken this edge forces a drop.
                        if (!r_valid || bus.out_ready) begin
                            w_dout_nxt  = w_shifted;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_ovr_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_order <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_order <= w_order_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign bus.data_out   = r_dout;
    assign bus.data_valid = r_valid;
    assign bus.busy       = (r_state == ST_COLLECT);
    assign bus.bit_count  = r_cnt;
    assign bus.overrun    = r_ovr;

endmodule
`default_nettype wire

// File: doc/usr_serial_deserializer.md
Name: usr_serial_deserializer

Overview:
- Receive end of the universal-shift-register serial link: collects a bit stream shifted out of a USR and rebuilds parallel words.
- Supports MSB-first (USR shift-left source) and LSB-first (USR shift-right source) ordering.
- Presents each completed word on a one-entry output register with a valid/ready handshake.
- Flags overrun when a word completes while the previous word is still unconsumed.

Parameters:
- WIDTH, 4, word width in bits; legal range 2 to 32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is sampled only on edges where this is 1.
- lsb_first  input  1  bit order: 0 = MSB-first, 1 = LSB-first. Latched with the first bit of each frame.
- abort  input  1  discards the partial frame.
- out_ready  input  1  consumer accepts data_out.
- clear_ovr  input  1  clears overrun.
- data_out  output  WIDTH  last completed word.
- data_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a frame is partially collected.
- bit_count  output  CNT_W  number of bits collected in the current frame.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (reset=0, asynchronous): shift register, data_out, bit_count, data_valid, busy, overrun and the latched order all go to 0. The state machine goes to IDLE.
- States:
  - IDLE (bit_count=0, busy=0): the first edge with serial_valid=1 samples the bit, latches lsb_first, sets bit_count=1 and moves to COLLECT.
  - COLLECT (busy=1): each edge with serial_valid=1 shifts in one bit and increments bit_count. Edges with serial_valid=0 hold all state.
  - Frame completion: on the edge that samples bit number WIDTH, the assembled word goes to the output register, bit_count returns to 0 and the state returns to IDLE.
  - A WIDTH-bit frame spans at least WIDTH sampling edges, with no dead cycle between frames.
- Shift rules:
  - MSB-first: sh = {sh[WIDTH-2:0], serial_in}.
  - LSB-first: sh = {serial_in, sh[WIDTH-1:1]}.
  - The first bit received ends up at the MSB (MSB-first) or the LSB (LSB-first).
  - Changing lsb_first mid-frame has no effect until the next frame.
- Output latency: data_out and data_valid update on the same edge that samples the last bit, so they are visible in the cycle after that edge.
- Handshake:
  - A transfer occurs on an edge where data_valid=1 and out_ready=1; data_valid then clears unless a new word loads on the same edge.
  - data_out is stable while data_valid=1 and out_ready=0.
- Completion cases, evaluated at the completion edge:
  - data_valid=0: load the word, set data_valid=1.
  - data_valid=1 and out_ready=1: load the new word, keep data_valid=1, no overrun.
  - data_valid=1 and out_ready=0: drop the new word, keep data_out, set overrun=1.
- Overrun: stays 1 until an edge with clear_ovr=1. If clear_ovr and a new overrun occur on the same edge, overrun remains 1.
- abort:
  - Returns to IDLE with bit_count=0 and discards any bit sampled on that edge (abort wins over serial_valid).
  - Does not touch data_out, data_valid or overrun.
- Reset mid-frame: the partial word is lost; the next valid bit after reset deasserts starts a clean frame.

Test Plan (WIDTH=4):
1. MSB-first: reset pulse, then serial_valid=1 with bits 1,0,1,0 on 4 consecutive edges -> after the 4th edge data_out=4'b1010, data_valid=1, busy=0, bit_count=0.
2. LSB-first: bits 1,1,0,0 -> data_out=4'b0011. Repeat with bits 1,1,1,0 -> data_out=4'b0111.
3. Gaps: bits 0,1 (MSB-first), then 3 cycles of serial_valid=0 with serial_in toggling, then 0,1 -> bit_count holds at 2 through the gap; data_out=4'b0101.
4. Overrun: complete 4'b1010 with out_ready=0, then 4'b0110 -> data_out stays 4'b1010, overrun=1. Then pulse out_ready -> data_valid=0. Then pulse clear_ovr -> overrun=0.
5. Back-to-back with consume: first word complete, second word's last bit on an edge with out_ready=1 -> data_out=new word, data_valid stays 1, overrun=0.
6. Reset and abort mid-frame:
   - Reset after 2 bits -> all outputs 0; the next 4 bits 1,0,1,0 yield exactly 4'b1010.
   - abort on the edge that carries a 3rd bit -> bit_count=0, busy=0; data_out unchanged.
